// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front end for the 32-bit combinational ALU.
// Decodes opcodes into the ALU's one-hot control lines, runs multi-bit
// shifts as repeated 1-bit ALU passes, and returns a registered response.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_EXEC  | single ALU pass for ADD/SUB/AND/OR, result captured
// S_SHIFT | one 1-bit shift pass per cycle until the count runs out
// S_RESP  | response presented, held until rsp_ready
module alu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [2:0]         i_cmd_op,
  input  logic [WIDTH-1:0]   i_cmd_a,
  input  logic [WIDTH-1:0]   i_cmd_b,
  input  logic [SHAMT_W-1:0] i_cmd_shamt,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  output logic               o_alu_AS,
  output logic               o_alu_sub,
  output logic               o_alu_Shift,
  output logic               o_alu_shift_left,
  output logic               o_alu_bitwiseAND,
  output logic               o_alu_bitwiseOR,
  input  logic [WIDTH-1:0]   i_alu_out,
  input  logic               i_alu_cout,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [WIDTH-1:0]   o_rsp_result,
  output logic               o_rsp_cout,
  output logic               o_rsp_err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_as;
  logic               r_sub;
  logic               r_shift;
  logic               r_shl;
  logic               r_and;
  logic               r_or;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_cout;
  logic               r_rsp_err;

  // Ready is gated by reset so nothing is accepted while reset is asserted.
  assign o_cmd_ready      = i_rst_n & (r_state == S_IDLE);

  assign o_alu_a          = r_op_a;
  assign o_alu_b          = r_op_b;
  assign o_alu_AS         = r_as;
  assign o_alu_sub        = r_sub;
  assign o_alu_Shift      = r_shift;
  assign o_alu_shift_left = r_shl;
  assign o_alu_bitwiseAND = r_and;
  assign o_alu_bitwiseOR  = r_or;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_result     = r_rsp_result;
  assign o_rsp_cout       = r_rsp_cout;
  assign o_rsp_err        = r_rsp_err;

  // Sequencer FSM; control lines are registered and set on entry to
  // EXEC/SHIFT, cleared on the edge that leaves them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cnt        <= '0;
      r_as         <= 1'b0;
      r_sub        <= 1'b0;
      r_shift      <= 1'b0;
      r_shl        <= 1'b0;
      r_and        <= 1'b0;
      r_or         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_op_a    <= i_cmd_a;
            r_op_b    <= i_cmd_b;
            r_cnt     <= i_cmd_shamt;
            r_rsp_err <= 1'b0;
            case (i_cmd_op)
              OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                r_as    <= (i_cmd_op == OP_ADD) || (i_cmd_op == OP_SUB);
                r_sub   <= (i_cmd_op == OP_SUB);
                r_and   <= (i_cmd_op == OP_AND);
                r_or    <= (i_cmd_op == OP_OR);
                r_state <= S_EXEC;
              end
              OP_SHL, OP_SHR: begin
                if (i_cmd_shamt != '0) begin
                  r_shift <= 1'b1;
                  r_shl   <= (i_cmd_op == OP_SHL);
                  r_state <= S_SHIFT;
                end else begin
                  // Zero-length shift: operand passes straight through.
                  r_rsp_result <= i_cmd_a;
                  r_rsp_cout   <= 1'b0;
                  r_rsp_valid  <= 1'b1;
                  r_state      <= S_RESP;
                end
              end
              default: begin
                r_rsp_result <= '0;
                r_rsp_cout   <= 1'b0;
                r_rsp_err    <= 1'b1;
                r_rsp_valid  <= 1'b1;
                r_state      <= S_RESP;
              end
            endcase
          end
        end
        S_EXEC: begin
          r_rsp_result <= i_alu_out;
          r_rsp_cout   <= r_as ? i_alu_cout : 1'b0;
          r_rsp_valid  <= 1'b1;
          r_as         <= 1'b0;
          r_sub        <= 1'b0;
          r_and        <= 1'b0;
          r_or         <= 1'b0;
          r_state      <= S_RESP;
        end
        S_SHIFT: begin
          r_op_a <= i_alu_out;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_rsp_result <= i_alu_out;
            r_rsp_cout   <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_shift      <= 1'b0;
            r_shl        <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU, directed vector table,
// hand-written backpressure/reset sequences and randomized commands.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [4:0]  cmd_shamt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_AS, alu_sub, alu_Shift, alu_shift_left, alu_and, alu_or;
  logic [31:0] alu_out;
  logic        alu_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_cout;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_op         (cmd_op),
    .i_cmd_a          (cmd_a),
    .i_cmd_b          (cmd_b),
    .i_cmd_shamt      (cmd_shamt),
    .o_alu_a          (alu_a),
    .o_alu_b          (alu_b),
    .o_alu_AS         (alu_AS),
    .o_alu_sub        (alu_sub),
    .o_alu_Shift      (alu_Shift),
    .o_alu_shift_left (alu_shift_left),
    .o_alu_bitwiseAND (alu_and),
    .o_alu_bitwiseOR  (alu_or),
    .i_alu_out        (alu_out),
    .i_alu_cout       (alu_cout),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_result     (rsp_result),
    .o_rsp_cout       (rsp_cout),
    .o_rsp_err        (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU; carry output always reflects the adder so the
  // sequencer must mask it for non-arithmetic ops.
  logic [32:0] w_add, w_sub;
  always_comb begin
    w_add    = {1'b0, alu_a} + {1'b0, alu_b};
    w_sub    = {1'b0, alu_a} - {1'b0, alu_b};
    alu_cout = alu_sub ? w_sub[32] : w_add[32];
    alu_out  = 32'h0;
    if (alu_AS)         alu_out = alu_sub ? w_sub[31:0] : w_add[31:0];
    else if (alu_and)   alu_out = alu_a & alu_b;
    else if (alu_or)    alu_out = alu_a | alu_b;
    else if (alu_Shift) alu_out = alu_shift_left ? (alu_a << 1) : (alu_a >> 1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: response fields, latency and control-pulse cycles.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output logic cout,
                       output logic err, output int lat, output int ctl);
    logic [32:0] s;
    res = 32'h0; cout = 1'b0; err = 1'b0; lat = 2; ctl = 1;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[31:0]; cout = s[32]; end
      3'd1: begin res = a - b; cout = (a < b); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4, 3'd5: begin
        res = (op == 3'd4) ? (a << sh) : (a >> sh);
        lat = (sh == 0) ? 1 : int'(sh) + 1;
        ctl = int'(sh);
      end
      default: begin err = 1'b1; lat = 1; ctl = 0; end
    endcase
  endtask

  function automatic logic ctl_bad(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic bad;
    n = int'(alu_AS) + int'(alu_and) + int'(alu_or) + int'(alu_Shift);
    bad = (n > 1);
    if (alu_AS && !(op == 3'd0 || op == 3'd1)) bad = 1'b1;
    if (alu_sub !== (alu_AS && op == 3'd1)) bad = 1'b1;
    if (alu_and && op != 3'd2) bad = 1'b1;
    if (alu_or && op != 3'd3) bad = 1'b1;
    if (alu_Shift && !(op == 3'd4 || op == 3'd5)) bad = 1'b1;
    if (alu_shift_left !== (alu_Shift && op == 3'd4)) bad = 1'b1;
    if ((alu_AS || alu_and || alu_or) && (alu_a !== a || alu_b !== b)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic any_ctl();
    return alu_AS | alu_sub | alu_Shift | alu_shift_left | alu_and | alu_or;
  endfunction

  task automatic run_cmd(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input int hold,
                         input logic [31:0] e_res, input logic e_cout, input logic e_err,
                         input int e_lat, input int e_ctl);
    int w;
    int cyc;
    int ctl;
    logic bad;
    logic hold_bad;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk({nm, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom; cmd_shamt = 5'($urandom);
    cyc = 1; ctl = 0; bad = 1'b0;
    while (!rsp_valid && cyc < 80) begin
      if (alu_AS || alu_and || alu_or || alu_Shift) ctl++;
      if (ctl_bad(op, a, b) || cmd_ready) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (any_ctl()) bad = 1'b1;
    chk({nm, " latency"}, 32'(cyc), 32'(e_lat));
    chk({nm, " ctl_cycles"}, 32'(ctl), 32'(e_ctl));
    chk({nm, " ctl_decode"}, 32'(bad), 32'd0);
    chk({nm, " result"}, rsp_result, e_res);
    chk({nm, " cout"}, 32'(rsp_cout), 32'(e_cout));
    chk({nm, " err"}, 32'(rsp_err), 32'(e_err));
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== e_res || rsp_cout !== e_cout ||
          rsp_err !== e_err || cmd_ready !== 1'b0 || any_ctl()) hold_bad = 1'b1;
    end
    if (hold > 0) chk({nm, " hold_stable"}, 32'(hold_bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, " rsp_done"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    int          hold;
    logic [31:0] res;
    logic        cout;
    logic        err;
    int          lat;
    int          ctl;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] m_res;
    logic        m_cout, m_err;
    int          m_lat, m_ctl;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_sh;

    vecs[0]  = '{"add_wrap",  3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  0, 32'h0000_0000, 1'b1, 1'b0, 2,  1};
    vecs[1]  = '{"sub_neg",   3'd1, 32'd5,         32'd7,         5'd0,  1, 32'hFFFF_FFFE, 1'b1, 1'b0, 2,  1};
    vecs[2]  = '{"sub_pos",   3'd1, 32'd7,         32'd5,         5'd0,  0, 32'h0000_0002, 1'b0, 1'b0, 2,  1};
    vecs[3]  = '{"shl4",      3'd4, 32'h8000_0001, 32'hFFFF_FFFF, 5'd4,  0, 32'h0000_0010, 1'b0, 1'b0, 5,  4};
    vecs[4]  = '{"shr31",     3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 2, 32'h0000_0001, 1'b0, 1'b0, 32, 31};
    vecs[5]  = '{"and",       3'd2, 32'hF0F0_F0F0, 32'h0FF0_00FF, 5'd0,  0, 32'h00F0_00F0, 1'b0, 1'b0, 2,  1};
    vecs[6]  = '{"or",        3'd3, 32'hF0F0_F0F0, 32'h0FF0_00FF, 5'd0,  0, 32'hFFF0_F0FF, 1'b0, 1'b0, 2,  1};
    vecs[7]  = '{"and_nocy",  3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  0, 32'h0000_0001, 1'b0, 1'b0, 2,  1};
    vecs[8]  = '{"shl0",      3'd4, 32'h1234_5678, 32'hFFFF_FFFF, 5'd0,  0, 32'h1234_5678, 1'b0, 1'b0, 1,  0};
    vecs[9]  = '{"shr1",      3'd5, 32'h0000_0003, 32'hFFFF_FFFF, 5'd1,  0, 32'h0000_0001, 1'b0, 1'b0, 2,  1};
    vecs[10] = '{"illegal7",  3'd7, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3,  5, 32'h0000_0000, 1'b0, 1'b1, 1,  0};
    vecs[11] = '{"illegal6",  3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  0, 32'h0000_0000, 1'b0, 1'b1, 1,  0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = '0; cmd_b = '0; cmd_shamt = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rsp", {29'd0, rsp_valid, rsp_cout, rsp_err}, 32'd0);
    chk("reset result", rsp_result, 32'd0);
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_b", alu_b, 32'd0);
    chk("reset ctl", 32'(any_ctl()), 32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 12; i++)
      run_cmd(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].hold,
              vecs[i].res, vecs[i].cout, vecs[i].err, vecs[i].lat, vecs[i].ctl);

    // Reset during SHIFT cycle 2 of a 10-bit shift.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 32'h0000_0001; cmd_b = 32'h0; cmd_shamt = 5'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst ctl", 32'(any_ctl()), 32'd0);
    chk("midrst alu_a", alu_a, 32'd0);
    chk("midrst cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after midrst", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    run_cmd("add_after_rst", 3'd0, 32'h0000_1000, 32'h0000_0234, 5'd0, 0,
            32'h0000_1234, 1'b0, 1'b0, 2, 1);

    for (int i = 0; i < 150; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? ~r_a : $urandom;
      r_sh = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      model(r_op, r_a, r_b, r_sh, m_res, m_cout, m_err, m_lat, m_ctl);
      run_cmd($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, r_sh,
              $urandom_range(0, 3), m_res, m_cout, m_err, m_lat, m_ctl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
